// File: rtl/obi_seq_pkg.sv
// ============================================================================
// Module  : obi_seq_pkg
// Brief   : Shared types for the OBI sequence master.
// Revision: 1.0
// ============================================================================
`default_nettype none

package obi_seq_pkg;

  typedef enum logic [1:0] {
    MODE_WRITE  = 2'd0,
    MODE_READ   = 2'd1,
    MODE_VERIFY = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    RESP   = 3'd2,
    SWITCH = 3'd3,
    DONE   = 3'd4
  } state_e;

  typedef enum logic {
    PASS_READ  = 1'b0,
    PASS_WRITE = 1'b1
  } pass_e;

  // The unused encoding 3 behaves as a plain read burst.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd0:    return MODE_WRITE;
      2'd2:    return MODE_VERIFY;
      default: return MODE_READ;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/obi_seq_timeout.sv
// ============================================================================
// Module  : obi_seq_timeout
// Brief   : Per-phase wait counter; flags the TIMEOUT-th enabled cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module obi_seq_timeout #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned c_CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT - 1);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && (r_cnt != c_LAST)) begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  assign expired_o = en_i && (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/obi_seq_master.sv
// ============================================================================
// Module  : obi_seq_master
// Brief   : Programmed-burst OBI master: write, read, or write-then-verify.
// Revision: 1.0
// ============================================================================
`default_nettype none

module obi_seq_master
  import obi_seq_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           MAX_WORDS   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           ADDR_STRIDE = 4,
  parameter int unsigned           TIMEOUT     = 64,
  localparam int unsigned          LEN_W       = $clog2(MAX_WORDS + 1)
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    start_i,
  input  logic [1:0]              mode_i,
  input  logic [LEN_W-1:0]        len_i,
  input  logic [DATA_WIDTH-1:0]   seed_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [LEN_W-1:0]        err_cnt_o,
  output logic                    rd_valid_o,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic                    obi_req_o,
  input  logic                    obi_gnt_i,
  output logic [ADDR_WIDTH-1:0]   obi_addr_o,
  output logic                    obi_we_o,
  output logic [DATA_WIDTH/8-1:0] obi_be_o,
  output logic [DATA_WIDTH-1:0]   obi_wdata_o,
  input  logic                    obi_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   obi_rdata_i
);

  localparam logic [LEN_W-1:0]      c_MAX_LEN = LEN_W'(MAX_WORDS);
  localparam logic [ADDR_WIDTH-1:0] c_STRIDE  = ADDR_WIDTH'(ADDR_STRIDE);

  state_e                  r_state, w_state_nxt;
  mode_e                   r_mode;
  pass_e                   r_pass;
  logic [LEN_W-1:0]        r_len, r_k, r_err_cnt;
  logic [DATA_WIDTH-1:0]   r_seed, r_pat, r_rd_data;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_err, r_rd_valid;

  logic [LEN_W-1:0]        w_len_in;
  mode_e                   w_mode_in;
  logic                    w_last, w_tmo, w_tmo_clr, w_tmo_en;

  assign w_len_in  = (len_i > c_MAX_LEN) ? c_MAX_LEN : len_i;
  assign w_mode_in = decode_mode(mode_i);
  assign w_last    = (r_k == (r_len - LEN_W'(1)));

  // One counter serves both wait phases; any state change restarts it.
  assign w_tmo_clr = (w_state_nxt != r_state);
  assign w_tmo_en  = (r_state == REQ) || (r_state == RESP);

  obi_seq_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .clr_i     (w_tmo_clr),
    .en_i      (w_tmo_en),
    .expired_o (w_tmo)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy_o      = (r_state != IDLE);
    done_o      = (r_state == DONE);
    obi_req_o   = (r_state == REQ);
    unique case (r_state)
      IDLE: begin
        // Empty bursts route through SWITCH so no request is ever raised.
        if (start_i) w_state_nxt = (w_len_in == '0) ? SWITCH : REQ;
      end
      REQ: begin
        if (obi_gnt_i)  w_state_nxt = RESP;
        else if (w_tmo) w_state_nxt = DONE;
      end
      RESP: begin
        if (obi_rvalid_i) begin
          if (!w_last)
            w_state_nxt = REQ;
          else if ((r_mode == MODE_VERIFY) && (r_pass == PASS_WRITE))
            w_state_nxt = SWITCH;
          else
            w_state_nxt = DONE;
        end else if (w_tmo) begin
          w_state_nxt = DONE;
        end
      end
      SWITCH:  w_state_nxt = (r_len == '0) ? DONE : REQ;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_mode     <= MODE_WRITE;
      r_pass     <= PASS_READ;
      r_len      <= '0;
      r_k        <= '0;
      r_seed     <= '0;
      r_pat      <= '0;
      r_addr     <= '0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            r_mode    <= w_mode_in;
            r_len     <= w_len_in;
            r_seed    <= seed_i;
            r_pat     <= seed_i;
            r_k       <= '0;
            r_addr    <= BASE_ADDR;
            r_pass    <= (w_mode_in == MODE_READ) ? PASS_READ : PASS_WRITE;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
          end
        end
        REQ: begin
          if (!obi_gnt_i && w_tmo) r_err <= 1'b1;
        end
        RESP: begin
          if (obi_rvalid_i) begin
            if (r_pass == PASS_READ) begin
              r_rd_valid <= 1'b1;
              r_rd_data  <= obi_rdata_i;
              if ((r_mode == MODE_VERIFY) && (obi_rdata_i != r_pat)) begin
                r_err <= 1'b1;
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + LEN_W'(1);
              end
            end
            if (!w_last) begin
              r_k    <= r_k + LEN_W'(1);
              r_addr <= r_addr + c_STRIDE;
              r_pat  <= r_pat + DATA_WIDTH'(1);
            end
          end else if (w_tmo) begin
            r_err <= 1'b1;
          end
        end
        SWITCH: begin
          r_k    <= '0;
          r_addr <= BASE_ADDR;
          r_pat  <= r_seed;
          r_pass <= PASS_READ;
        end
        default: ;
      endcase
    end
  end

  assign err_o       = r_err;
  assign err_cnt_o   = r_err_cnt;
  assign rd_valid_o  = r_rd_valid;
  assign rd_data_o   = r_rd_data;
  assign obi_addr_o  = r_addr;
  assign obi_we_o    = (r_pass == PASS_WRITE);
  assign obi_be_o    = '1;
  assign obi_wdata_o = (r_pass == PASS_WRITE) ? r_pat : '0;

endmodule

`default_nettype wire

// File: tb/tb_obi_seq_master.sv
// ============================================================================
// Module  : tb_obi_seq_master
// Brief   : Directed self-checking bench with a small OBI slave memory model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_obi_seq_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [3:0]  len = 4'd0;
  logic [31:0] seed = 32'd0;
  logic        busy, done, err, rd_valid;
  logic [3:0]  err_cnt;
  logic [31:0] rd_data;
  logic        obi_req, obi_we;
  logic        obi_gnt = 1'b0;
  logic        obi_rvalid = 1'b0;
  logic [31:0] obi_addr, obi_wdata;
  logic [31:0] obi_rdata = 32'd0;
  logic [3:0]  obi_be;

  int errors = 0;
  int checks = 0;

  obi_seq_master dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .start_i      (start),
    .mode_i       (mode),
    .len_i        (len),
    .seed_i       (seed),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .err_cnt_o    (err_cnt),
    .rd_valid_o   (rd_valid),
    .rd_data_o    (rd_data),
    .obi_req_o    (obi_req),
    .obi_gnt_i    (obi_gnt),
    .obi_addr_o   (obi_addr),
    .obi_we_o     (obi_we),
    .obi_be_o     (obi_be),
    .obi_wdata_o  (obi_wdata),
    .obi_rvalid_i (obi_rvalid),
    .obi_rdata_i  (obi_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Slave model and monitor state
  logic [31:0] mem [16];
  logic        slave_en = 1'b1;
  logic        gnt_rand = 1'b0;
  logic        withhold = 1'b0;
  logic        corrupt_en = 1'b0;
  logic [3:0]  corrupt_idx = 4'd0;
  logic        pend = 1'b0;
  logic        pend_we = 1'b0;
  logic [3:0]  pend_idx = 4'd0;
  int          wait_cnt = 0;
  logic [31:0] tx_addr[$];
  logic [31:0] tx_wdata[$];
  logic        tx_we[$];
  logic [31:0] rd_q[$];
  int done_cnt, done_cyc, req_cycles, first_req_cyc, hs_cyc, start_cyc;

  always @(negedge clk) begin
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (rd_valid) rd_q.push_back(rd_data);
    if (obi_req) begin
      req_cycles++;
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (slave_en) begin
      obi_rvalid = 1'b0;
      obi_gnt    = 1'b0;
      if (pend) begin
        pend = 1'b0;
        if (!withhold) begin
          obi_rvalid = 1'b1;
          obi_rdata  = pend_we ? 32'd0 : mem[pend_idx];
          if (!pend_we && corrupt_en && pend_idx == corrupt_idx) obi_rdata = obi_rdata ^ 32'h1;
        end
      end
      if (obi_req) begin
        if (wait_cnt == 0) begin
          obi_gnt  = 1'b1;
          pend     = 1'b1;
          pend_we  = obi_we;
          pend_idx = obi_addr[5:2];
          hs_cyc   = cyc;
          tx_addr.push_back(obi_addr);
          tx_wdata.push_back(obi_wdata);
          tx_we.push_back(obi_we);
          if (obi_we) mem[obi_addr[5:2]] = obi_wdata;
          wait_cnt = gnt_rand ? int'($urandom_range(0, 3)) : 0;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  task automatic clear_logs();
    tx_addr.delete(); tx_wdata.delete(); tx_we.delete(); rd_q.delete();
    done_cnt = 0; done_cyc = -1; req_cycles = 0; first_req_cyc = -1; hs_cyc = -1;
    pend = 1'b0; wait_cnt = 0; corrupt_en = 1'b0; withhold = 1'b0; gnt_rand = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [3:0] l, input logic [31:0] s);
    @(negedge clk);
    start = 1'b1; mode = m; len = l; seed = s;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++; $display("FAIL wait_done: no done_o within %0d cycles", budget);
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err !== 1'b0 || err_cnt !== 4'd0) begin errors++; $display("FAIL reset_err: got %b/%0d want 0/0", err, err_cnt); end
    checks++; if (obi_req !== 1'b0 || obi_we !== 1'b0) begin errors++; $display("FAIL reset_req: got req=%b we=%b want 0", obi_req, obi_we); end
    checks++; if (obi_be !== 4'hF) begin errors++; $display("FAIL reset_be: got %h want f", obi_be); end
    checks++; if (obi_addr !== 32'd0 || obi_wdata !== 32'd0 || rd_data !== 32'd0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_data: addr=%h wdata=%h rd=%h rv=%b want 0", obi_addr, obi_wdata, rd_data, rd_valid); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    clear_logs();
    do_start(2'd0, 4'd4, 32'h10);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b want 1", busy); end
    wait_done(200);
    checks++; if (first_req_cyc != start_cyc + 1) begin errors++; $display("FAIL write_first_req: got cyc %0d want %0d", first_req_cyc, start_cyc + 1); end
    checks++; if (tx_addr.size() != 4) begin errors++; $display("FAIL write_count: got %0d want 4", tx_addr.size()); end
    for (int k = 0; k < 4 && k < tx_addr.size(); k++) begin
      checks++;
      if (tx_addr[k] !== 32'(4 * k) || tx_wdata[k] !== 32'h10 + 32'(k) || tx_we[k] !== 1'b1) begin
        errors++; $display("FAIL write_tx%0d: got addr=%h wdata=%h we=%b want addr=%h wdata=%h we=1",
                           k, tx_addr[k], tx_wdata[k], tx_we[k], 32'(4 * k), 32'h10 + 32'(k)); end
    end
    checks++; if (done_cnt != 1 || err !== 1'b0 || rd_q.size() != 0) begin
      errors++; $display("FAIL write_end: got done=%0d err=%b rd=%0d want 1/0/0", done_cnt, err, rd_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_verify();
    clear_logs();
    gnt_rand = 1'b1;
    do_start(2'd2, 4'd3, 32'hA0);
    wait_done(300);
    checks++; if (tx_addr.size() != 6) begin errors++; $display("FAIL verify_count: got %0d want 6", tx_addr.size()); end
    for (int k = 0; k < 6 && k < tx_addr.size(); k++) begin
      checks++;
      if (tx_we[k] !== (k < 3) || tx_addr[k] !== 32'(4 * (k % 3))) begin
        errors++; $display("FAIL verify_tx%0d: got we=%b addr=%h want we=%b addr=%h", k, tx_we[k], tx_addr[k], k < 3, 32'(4 * (k % 3))); end
    end
    checks++; if (rd_q.size() != 3) begin errors++; $display("FAIL verify_rdcount: got %0d want 3", rd_q.size()); end
    for (int k = 0; k < 3 && k < rd_q.size(); k++) begin
      checks++;
      if (rd_q[k] !== 32'hA0 + 32'(k)) begin errors++; $display("FAIL verify_rd%0d: got %h want %h", k, rd_q[k], 32'hA0 + 32'(k)); end
    end
    checks++; if (err_cnt !== 4'd0 || err !== 1'b0) begin errors++; $display("FAIL verify_err: got %0d/%b want 0/0", err_cnt, err); end
  endtask

  task automatic test_verify_corrupt();
    clear_logs();
    corrupt_en = 1'b1; corrupt_idx = 4'd1;
    do_start(2'd2, 4'd2, 32'h55);
    wait_done(200);
    checks++; if (tx_addr.size() != 4 || done_cnt != 1) begin
      errors++; $display("FAIL corrupt_count: got tx=%0d done=%0d want 4/1", tx_addr.size(), done_cnt); end
    checks++; if (err !== 1'b1 || err_cnt !== 4'd1) begin
      errors++; $display("FAIL corrupt_err: got err=%b cnt=%0d want 1/1", err, err_cnt); end
  endtask

  task automatic test_timeout();
    clear_logs();
    withhold = 1'b1;
    do_start(2'd1, 4'd2, 32'h0);
    wait_done(200);
    checks++; if (tx_addr.size() != 1 || req_cycles != 1) begin
      errors++; $display("FAIL timeout_reqs: got tx=%0d req_cycles=%0d want 1/1", tx_addr.size(), req_cycles); end
    checks++; if (done_cyc - hs_cyc != 65) begin errors++; $display("FAIL timeout_latency: got %0d want 65", done_cyc - hs_cyc); end
    checks++; if (err !== 1'b1 || done_cnt != 1 || rd_q.size() != 0) begin
      errors++; $display("FAIL timeout_end: got err=%b done=%0d rd=%0d want 1/1/0", err, done_cnt, rd_q.size()); end
  endtask

  task automatic test_len0();
    clear_logs();
    do_start(2'd0, 4'd0, 32'h1);
    wait_done(50);
    checks++; if (req_cycles != 0) begin errors++; $display("FAIL len0_req: got %0d req cycles want 0", req_cycles); end
    checks++; if (done_cyc != start_cyc + 2) begin errors++; $display("FAIL len0_done: got cyc %0d want %0d", done_cyc, start_cyc + 2); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL len0_err: got %b want 0", err); end
  endtask

  task automatic test_start_ignored();
    clear_logs();
    do_start(2'd0, 4'd3, 32'h0);
    repeat (2) @(negedge clk);
    start = 1'b1; mode = 2'd1; len = 4'd8;
    @(negedge clk);
    start = 1'b0;
    wait_done(200);
    repeat (10) @(negedge clk);
    #1;
    checks++; if (tx_addr.size() != 3 || done_cnt != 1) begin
      errors++; $display("FAIL ignore_count: got tx=%0d done=%0d want 3/1", tx_addr.size(), done_cnt); end
    checks++; if (tx_we.size() == 3 && (tx_we[0] & tx_we[1] & tx_we[2]) !== 1'b1) begin
      errors++; $display("FAIL ignore_we: got %b%b%b want 111", tx_we[0], tx_we[1], tx_we[2]); end
  endtask

  task automatic test_clamp();
    clear_logs();
    for (int i = 0; i < 16; i++) mem[i] = 32'hC000_0000 + 32'(i);
    do_start(2'd3, 4'd15, 32'h0);
    wait_done(300);
    checks++; if (tx_addr.size() != 8 || rd_q.size() != 8) begin
      errors++; $display("FAIL clamp_count: got tx=%0d rd=%0d want 8/8", tx_addr.size(), rd_q.size()); end
    for (int k = 0; k < 8 && k < tx_addr.size() && k < rd_q.size(); k++) begin
      checks++;
      if (tx_we[k] !== 1'b0 || tx_addr[k] !== 32'(4 * k) || rd_q[k] !== 32'hC000_0000 + 32'(k)) begin
        errors++; $display("FAIL clamp_tx%0d: got we=%b addr=%h rd=%h want 0/%h/%h",
                           k, tx_we[k], tx_addr[k], rd_q[k], 32'(4 * k), 32'hC000_0000 + 32'(k)); end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    withhold = 1'b1;
    do_start(2'd1, 4'd2, 32'h0);
    repeat (4) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || obi_req !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs: got busy=%b req=%b done=%b err=%b want 0", busy, obi_req, done, err); end
    slave_en = 1'b0;
    obi_gnt = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    obi_rvalid = 1'b1; obi_rdata = 32'h1234_5678;
    @(negedge clk);
    obi_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rd_q.size() != 0 || rd_data !== 32'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_stray: got rd=%0d data=%h busy=%b want 0/0/0", rd_q.size(), rd_data, busy); end
    pend = 1'b0;
    slave_en = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
    clear_logs();
    test_reset();
    test_write();
    test_verify();
    test_verify_corrupt();
    test_timeout();
    test_len0();
    test_start_ignored();
    test_clamp();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
